// File: rtl/sig_pkg.sv
// Shared definitions for the signal chain (averager and interpolator):
// handshake FSM states and default sizing constants.
package sig_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DATLEN        = 12;
  localparam int INTERP_N      = 64;
  localparam int INTERP_N_LOG2 = 6;

endpackage

// File: rtl/interp_acc.sv
// Linear-ramp accumulator: loads base << log2(n) and the signed step delta,
// then adds delta on every step; the output sample is the scaled-down value.
module interp_acc
  import sig_pkg::*;
#(
  parameter int datlen        = DATLEN,
  parameter int interp_n_log2 = INTERP_N_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [datlen-1:0] base,
  input  logic [datlen-1:0] target,
  output logic [datlen-1:0] val
);

  localparam int AW = datlen + interp_n_log2 + 1;

  logic signed [AW-1:0] acc;
  logic signed [datlen:0] delta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      delta <= '0;
    end else if (load) begin
      acc   <= $signed({1'b0, base, {interp_n_log2{1'b0}}});
      delta <= $signed({1'b0, target}) - $signed({1'b0, base});
    end else if (step) begin
      acc <= acc + AW'(delta);
    end
  end

  // The ramp always lies between base and target, so acc never goes negative
  // and dropping the low bits is a floor.
  assign val = acc[datlen+interp_n_log2-1:interp_n_log2];

endmodule

// File: rtl/sig_interp.sv
// Sample-rate interpolator: each accepted target value is expanded into
// interp_n samples ramping linearly from the previously emitted target.
module sig_interp
  import sig_pkg::*;
#(
  parameter int datlen        = DATLEN,
  parameter int interp_n      = INTERP_N,
  parameter int interp_n_log2 = INTERP_N_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [datlen-1:0] in_val,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [datlen-1:0] out_val,
  output logic              out_valid,
  input  logic              out_ready,
  output state_t            dbg_state
);

  localparam logic [interp_n_log2-1:0] K_LAST = interp_n_log2'(interp_n - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a producer holding valid
  // keeps its data stable until the transfer.
  state_t                   state;
  state_t                   next_state;
  logic [interp_n_log2-1:0] k;
  logic [datlen-1:0]        prev;
  logic [datlen-1:0]        target;
  logic                     in_hs;
  logic                     out_hs;
  logic                     last;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last      = (k == K_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      prev   <= '0;
      target <= '0;
    end else begin
      state <= next_state;
      if (in_hs) begin
        k      <= '0;
        target <= in_val;
      end else if (out_hs) begin
        k <= k + 1'b1;
        if (last) prev <= target;
      end
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        if (out_ready && last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  interp_acc #(
    .datlen        (datlen),
    .interp_n_log2 (interp_n_log2)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .load   (in_hs),
    .step   (out_hs),
    .base   (prev),
    .target (in_val),
    .val    (out_val)
  );

endmodule

// File: doc/sig_interp.md
SIG_INTERP -- requirements
Module: sig_interp

Interface
REQ-001 The block SHALL have parameter datlen, default 12, width of each sample value (unsigned).
REQ-002 The block SHALL have parameter interp_n, default 64, number of output samples produced per accepted input value (power of two, >=2).
REQ-003 The block SHALL have parameter interp_n_log2, default 6, log2(interp_n), used for shifts and counter width.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port in_val  input  datlen  new target value (decimated average).
REQ-007 The block SHALL have port in_valid  input  1  in_val is valid this cycle.
REQ-008 The block SHALL have port in_ready  output  1  block accepts in_val this cycle.
REQ-009 The block SHALL have port out_val  output  datlen  interpolated sample.
REQ-010 The block SHALL have port out_valid  output  1  out_val is valid.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts out_val this cycle.

Function
REQ-012 The block SHALL implement states IDLE and RUN; IDLE->RUN on input handshake (in_valid & in_ready); RUN->IDLE on the output handshake of step interp_n-1.
REQ-013 The block SHALL drive in_ready=1 only in IDLE and out_valid=1 only in RUN.
REQ-014 The block SHALL hold a register prev (datlen, unsigned), the last fully emitted target, initialised to 0 by reset.
REQ-015 On input handshake the block SHALL latch delta = in_val - prev as signed (datlen+1) bits, load accumulator acc = prev << interp_n_log2, clear step counter k to 0, and latch in_val as target.
REQ-016 acc SHALL be signed, datlen+interp_n_log2+1 bits wide, with no overflow or saturation possible.
REQ-017 out_val SHALL equal acc >> interp_n_log2 (floor, i.e. truncation of a non-negative value), so step k outputs floor(prev + delta*k/interp_n).
REQ-018 On each output handshake the block SHALL set acc = acc + delta and k = k + 1; on the handshake with k = interp_n-1 it SHALL set prev = target and return to IDLE.
REQ-019 out_valid SHALL assert the cycle after the input handshake (latency 1), and exactly interp_n output handshakes SHALL occur per accepted input.
REQ-020 While out_valid=1 and out_ready=0, out_val, acc and k SHALL hold stable.
REQ-021 in_ready SHALL be 0 during RUN, including the cycle of the final output handshake, giving at least one bubble cycle between bursts.
REQ-022 With delta = 0, the block SHALL emit interp_n copies of prev.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, prev=0, acc=0, k=0, delta=0, out_valid=0, out_val=0 and in_ready=1, and SHALL discard any burst in progress without emitting remaining samples.
REQ-024 After rst deasserts, the first input handshake SHALL interpolate from 0.

Structure
REQ-025 The state enum (IDLE, RUN) and the default datlen/interp_n/interp_n_log2 constants SHALL reside in shared package sig_pkg, reused by the averager.
REQ-026 The accumulator/step logic MAY be a sub-module interp_acc (load, step enable, acc out), and the FSM and handshakes SHALL remain in sig_interp.

Verification (datlen=12, interp_n=4, interp_n_log2=2)
REQ-027 The bench SHALL check: reset, in_val=100 accepted, out_ready=1 -> out_val 0,25,50,75 on consecutive cycles, then in_ready=1.
REQ-028 The bench SHALL check: continuing, in_val=20 -> out_val 100,80,60,40.
REQ-029 The bench SHALL check: reset, in_val=4095 -> out_val 0,1023,2047,3071.
REQ-030 The bench SHALL check: out_ready low for 3 cycles mid-burst -> out_val and out_valid held unchanged, and the sequence then resumes without loss or duplication.
REQ-031 The bench SHALL check: rst pulsed after the 2nd output -> out_valid=0 immediately, and the next in_val=8 yields 0,2,4,6.
REQ-032 The bench SHALL check: in_valid held high throughout -> in_ready=0 during each burst, exactly 4 outputs per accepted input, and at least one idle cycle between bursts.
